// File: rtl/sensor_pkg.sv
// Shared types and constants for the A2D scheduler: channel encodings as seen
// by the SPI A2D interface, scheduler FSM states, default timing constants and
// small helpers for round-robin order and update-strobe bit mapping.
package sensor_pkg;

    // A2D multiplexer codes; channel 2 is not wired to a sensor.
    typedef enum logic [2:0] {
        CH_BATT   = 3'd0,
        CH_CURR   = 3'd1,
        CH_BRAKE  = 3'd3,
        CH_TORQUE = 3'd4
    } channel_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        LATCH
    } state_t;

    localparam int DEF_INTERVAL_REAL = 4096;
    localparam int DEF_INTERVAL_FAST = 64;
    localparam int DEF_TIMEOUT       = 1024;
    localparam int RES_W             = 12;

    // Round-robin order: batt -> curr -> brake -> torque -> batt.
    function automatic channel_t next_rr(input channel_t ch);
        channel_t nxt;
        unique case (ch)
            CH_BATT:   nxt = CH_CURR;
            CH_CURR:   nxt = CH_BRAKE;
            CH_BRAKE:  nxt = CH_TORQUE;
            CH_TORQUE: nxt = CH_BATT;
            default:   nxt = CH_BATT;
        endcase
        return nxt;
    endfunction

    // Update strobe position, bit order {torque, brake, curr, batt}.
    function automatic logic [3:0] upd_bit(input channel_t ch);
        logic [3:0] bits;
        unique case (ch)
            CH_BATT:   bits = 4'b0001;
            CH_CURR:   bits = 4'b0010;
            CH_BRAKE:  bits = 4'b0100;
            CH_TORQUE: bits = 4'b1000;
            default:   bits = 4'b0000;
        endcase
        return bits;
    endfunction

endpackage : sensor_pkg

// File: rtl/sched_timer.sv
// Free-running sample-interval counter. Counts 0..INTERVAL-1 and wraps,
// raising tick for the single cycle the count sits at its terminal value.
// FAST_SIM picks the short simulation interval instead of the silicon one.
module sched_timer
    import sensor_pkg::*;
#(
    parameter int FAST_SIM      = 1,
    parameter int INTERVAL_REAL = DEF_INTERVAL_REAL,
    parameter int INTERVAL_FAST = DEF_INTERVAL_FAST
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int INTERVAL = (FAST_SIM != 0) ? INTERVAL_FAST : INTERVAL_REAL;
    localparam int CNT_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(INTERVAL - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TERM);

    // Interval counter with wrap at the terminal count.
    // NOTE: sequential state uses <= so every flop samples pre-edge values,
    // independent of block ordering in the simulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule : sched_timer

// File: rtl/a2d_sched.sv
// Shares the single SPI A2D converter among battery, current, brake and
// torque conditioning. Channels are sampled round-robin once per interval
// tick; a cadence rising edge forces an out-of-order torque sample so torque
// is captured phase-aligned to the pedal stroke. Latest results are held per
// channel with a one-cycle update strobe; a hung conversion is abandoned
// after TIMEOUT cycles with an err_to pulse.
module a2d_sched
    import sensor_pkg::*;
#(
    parameter int FAST_SIM      = 1,
    parameter int INTERVAL_REAL = DEF_INTERVAL_REAL,
    parameter int INTERVAL_FAST = DEF_INTERVAL_FAST,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cadence_rise,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    output logic             strt_cnv,
    output logic [2:0]       chnnl,
    output logic [RES_W-1:0] batt,
    output logic [RES_W-1:0] curr,
    output logic [RES_W-1:0] brake,
    output logic [RES_W-1:0] torque,
    output logic [3:0]       upd,
    output logic             err_to
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t         state, state_nxt;
    channel_t       rr_ptr;
    channel_t       sel_ch;
    channel_t       sel_ch_nxt;
    logic           tick;
    logic           pend_tq, pend_tick;
    logic           sel_valid;
    logic           clr_tq, clr_tick;
    logic           to_expire;
    logic           cmplt_ok;
    logic [TO_W-1:0] to_cnt;

    sched_timer #(
        .FAST_SIM      (FAST_SIM),
        .INTERVAL_REAL (INTERVAL_REAL),
        .INTERVAL_FAST (INTERVAL_FAST)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Arbitration: torque requests win; a scheduled torque slot and a pending
    // cadence request are both satisfied by one conversion.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel_valid  = 1'b0;
        clr_tq     = 1'b0;
        clr_tick   = 1'b0;
        sel_ch_nxt = rr_ptr;
        if (state == IDLE && (pend_tq || pend_tick)) begin
            sel_valid = 1'b1;
            if (pend_tq) begin
                sel_ch_nxt = CH_TORQUE;
                clr_tq     = 1'b1;
                clr_tick   = pend_tick && (rr_ptr == CH_TORQUE);
            end else begin
                sel_ch_nxt = rr_ptr;
                clr_tick   = 1'b1;
            end
        end
    end

    assign cmplt_ok  = (state == WAIT) && cnv_cmplt;
    assign to_expire = (state == WAIT) && !cnv_cmplt && (to_cnt == TO_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sel_valid) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (cnv_cmplt)      state_nxt = LATCH;
                else if (to_expire) state_nxt = IDLE;
            end
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the conversion request is a single START-state cycle.
    always_comb begin
        strt_cnv = (state == START);
    end

    // Request flags; a new request wins over a same-cycle clear so no event
    // is lost while the previous one is being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_tq   <= 1'b0;
            pend_tick <= 1'b0;
        end else begin
            pend_tq   <= cadence_rise || (pend_tq && !clr_tq);
            pend_tick <= tick || (pend_tick && !clr_tick);
        end
    end

    // Round-robin pointer and the channel select held from START to LATCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= CH_BATT;
            sel_ch <= CH_BATT;
        end else begin
            if (clr_tick)
                rr_ptr <= next_rr(rr_ptr);
            if (sel_valid)
                sel_ch <= sel_ch_nxt;
        end
    end

    assign chnnl = sel_ch;

    // WAIT-state timeout counter, parked at zero outside WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state == WAIT)
            to_cnt <= to_cnt + 1'b1;
        else
            to_cnt <= '0;
    end

    // Result registers, captured while res is valid so they are visible in
    // LATCH alongside the matching update strobe.
    // NOTE: the sample registers are deliberately reset; downstream logic
    // reads them directly and must never see stale or X data after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batt   <= '0;
            curr   <= '0;
            brake  <= '0;
            torque <= '0;
        end else if (cmplt_ok) begin
            unique case (sel_ch)
                CH_BATT:   batt   <= res;
                CH_CURR:   curr   <= res;
                CH_BRAKE:  brake  <= res;
                CH_TORQUE: torque <= res;
                default: ;
            endcase
        end
    end

    // One-cycle update and timeout strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd    <= 4'b0000;
            err_to <= 1'b0;
        end else begin
            upd    <= cmplt_ok ? upd_bit(sel_ch) : 4'b0000;
            err_to <= to_expire;
        end
    end

endmodule : a2d_sched

// File: tb/tb_a2d_sched.sv
// Directed bench for a2d_sched in FAST_SIM mode. A small A2D model answers
// each strt_cnv three cycles later with res = chnnl*100 + res_ofs; the
// offset changes between phases so every new sample is distinguishable.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_a2d_sched;

    logic        clk;
    logic        rst_n;
    logic        cadence_rise;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] batt, curr, brake, torque;
    logic [3:0]  upd;
    logic        err_to;

    int total = 0;
    int bad   = 0;

    logic       model_en;
    logic [11:0] res_ofs;
    int         dly;

    a2d_sched #(
        .FAST_SIM      (1),
        .INTERVAL_REAL (4096),
        .INTERVAL_FAST (64),
        .TIMEOUT       (1024)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_rise (cadence_rise),
        .cnv_cmplt    (cnv_cmplt),
        .res          (res),
        .strt_cnv     (strt_cnv),
        .chnnl        (chnnl),
        .batt         (batt),
        .curr         (curr),
        .brake        (brake),
        .torque       (torque),
        .upd          (upd),
        .err_to       (err_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A2D model: cnv_cmplt three cycles after a strt_cnv cycle, driven just
    // after the rising edge.
    always @(posedge clk) begin
        #2;
        cnv_cmplt = 1'b0;
        if (dly != 0) begin
            dly = dly - 1;
            if (dly == 0 && model_en) begin
                cnv_cmplt = 1'b1;
                res = 12'(chnnl) * 12'd100 + res_ofs;
            end
        end
        if (strt_cnv)
            dly = 3;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Count falling edges until the chosen signal is high (0: strt_cnv,
    // 1: err_to), bounded by max.
    task automatic wait_sig(input int which, input int max, output int n);
        n = 0;
        while (n < max && !((which == 0) ? strt_cnv : err_to)) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        rst_n        = 1'b0;
        cadence_rise = 1'b0;
        cnv_cmplt    = 1'b0;
        res          = '0;
        model_en     = 1'b1;
        res_ofs      = '0;
        dly          = 0;

        // Reset state.
        step(3);
        chk("rst_strt", strt_cnv, 0);
        chk("rst_chnnl", chnnl, 0);
        chk("rst_upd", upd, 0);
        chk("rst_err", err_to, 0);
        chk("rst_batt", batt, 0);
        chk("rst_torque", torque, 0);
        rst_n = 1'b1;

        // Round-robin on successive ticks, 64 cycles apart.
        wait_sig(0, 200, n);
        chk("rr0_lat", n, 65);
        chk("rr0_ch", chnnl, 0);
        step(4);
        chk("rr0_upd", upd, 4'b0001);
        chk("rr0_batt", batt, 0);
        wait_sig(0, 200, n);
        chk("rr1_lat", n, 60);
        chk("rr1_ch", chnnl, 1);
        step(4);
        chk("rr1_upd", upd, 4'b0010);
        chk("rr1_curr", curr, 100);
        wait_sig(0, 200, n);
        chk("rr2_lat", n, 60);
        chk("rr2_ch", chnnl, 3);
        step(4);
        chk("rr2_upd", upd, 4'b0100);
        chk("rr2_brake", brake, 300);
        wait_sig(0, 200, n);
        chk("rr3_lat", n, 60);
        chk("rr3_ch", chnnl, 4);
        step(4);
        chk("rr3_upd", upd, 4'b1000);
        chk("rr3_torque", torque, 400);
        wait_sig(0, 200, n);
        chk("rr4_lat", n, 60);
        chk("rr4_ch", chnnl, 0);
        step(4);
        chk("rr4_upd", upd, 4'b0001);
        step(1);
        chk("upd_one_cycle", upd, 0);

        // cadence_rise on the tick cycle with rr at curr: torque first, then
        // curr straight after.
        res_ofs = 12'd7;
        step(57);
        cadence_rise = 1'b1;
        step(1);
        cadence_rise = 1'b0;
        wait_sig(0, 10, n);
        chk("coinc_tq_lat", n, 1);
        chk("coinc_tq_ch", chnnl, 4);
        step(4);
        chk("coinc_tq_upd", upd, 4'b1000);
        chk("coinc_tq_val", torque, 407);
        wait_sig(0, 10, n);
        chk("coinc_rr_lat", n, 2);
        chk("coinc_rr_ch", chnnl, 1);
        step(4);
        chk("coinc_rr_upd", upd, 4'b0010);
        chk("coinc_rr_val", curr, 107);

        // Single cadence_rise mid-interval while IDLE.
        res_ofs = 12'd20;
        step(1);
        cadence_rise = 1'b1;
        step(1);
        cadence_rise = 1'b0;
        chk("cad_pend_nostrt", strt_cnv, 0);
        step(1);
        chk("cad_strt", strt_cnv, 1);
        chk("cad_ch", chnnl, 4);
        step(4);
        chk("cad_upd", upd, 4'b1000);
        chk("cad_torque", torque, 420);
        wait_sig(0, 200, n);
        chk("cad_noskip_lat", n, 47);
        chk("cad_noskip_ch", chnnl, 3);
        step(4);
        chk("cad_noskip_brake", brake, 320);

        // Suppressed cnv_cmplt: timeout 1024 cycles after entering WAIT.
        model_en = 1'b0;
        wait_sig(0, 200, n);
        chk("to_strt_lat", n, 60);
        chk("to_strt_ch", chnnl, 4);
        wait_sig(1, 1100, n);
        chk("to_err_lat", n, 1025);
        chk("to_err", err_to, 1);
        chk("to_no_upd", upd, 0);
        chk("to_torque_kept", torque, 420);
        model_en = 1'b1;
        wait_sig(0, 10, n);
        chk("to_next_lat", n, 1);
        chk("to_err_pulse", err_to, 0);
        chk("to_next_ch", chnnl, 0);
        step(4);
        chk("to_next_upd", upd, 4'b0001);
        chk("to_next_batt", batt, 20);

        // Reset during WAIT, late cnv_cmplt after release.
        wait_sig(0, 200, n);
        chk("rw_strt_lat", n, 58);
        chk("rw_strt_ch", chnnl, 1);
        res_ofs = 12'd50;
        step(2);
        rst_n = 1'b0;
        #1;
        chk("rw_batt", batt, 0);
        chk("rw_curr", curr, 0);
        chk("rw_brake", brake, 0);
        chk("rw_torque", torque, 0);
        chk("rw_chnnl", chnnl, 0);
        chk("rw_upd", upd, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("rw_late_upd", upd, 0);
        chk("rw_late_batt", batt, 0);
        wait_sig(0, 200, n);
        chk("rw_first_lat", n, 64);
        chk("rw_first_ch", chnnl, 0);
        step(4);
        chk("rw_first_upd", upd, 4'b0001);
        chk("rw_first_batt", batt, 50);
        chk("rw_curr_clear", curr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_a2d_sched

// File: doc/a2d_sched.md
Name: a2d_sched

Overview:
- Scheduler/arbiter that shares the single SPI A2D converter among the four sensor-conditioning channels: battery, current, brake and torque.
- Services channels round-robin on a fixed sample interval.
- A cadence_rise pulse (one-cycle rising-edge strobe produced by the cadence measurement logic) forces an out-of-order torque sample, so torque is captured phase-aligned to the pedal stroke.
- Holds the latest 12-bit result per channel for downstream sensor conditioning.

Parameters:
FAST_SIM, 1, selects interval/timeout constants: 1 = simulation values, 0 = silicon values.
INTERVAL_REAL, 4096, cycles between scheduled conversions when FAST_SIM=0.
INTERVAL_FAST, 64, cycles between scheduled conversions when FAST_SIM=1.
TIMEOUT, 1024, max cycles in WAIT before abort (both modes).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
cadence_rise  in  1  one-cycle pulse per pedal rising edge
cnv_cmplt  in  1  A2D done strobe, one cycle, valid with res
res  in  12  A2D conversion result
strt_cnv  out  1  one-cycle conversion request to A2D interface
chnnl  out  3  A2D channel select (battery=0, current=1, brake=3, torque=4)
batt  out  12  latest battery sample
curr  out  12  latest current sample
brake  out  12  latest brake sample
torque  out  12  latest torque sample
upd  out  4  one-cycle update pulse, bit order {torque,brake,curr,batt}
err_to  out  1  one-cycle pulse on conversion timeout

Behaviour:
- Reset (async): all sample registers 0, upd 0, strt_cnv 0, chnnl 0, err_to 0, FSM IDLE, rr pointer = batt, pend_tq 0, pend_tick 0, interval counter 0.
- Interval counter: free-running, counts 0..INTERVAL-1, wraps. Asserts tick for the cycle it equals INTERVAL-1. Tick sets pend_tick; pend_tick is cleared only when consumed in IDLE.
- cadence_rise sets pend_tq in any state. Multiple rises before service collapse to one request.
- FSM IDLE:
  - If pend_tq: select torque; clear pend_tq; rr pointer unchanged.
  - Else if pend_tick: select channel at rr pointer; clear pend_tick; advance rr pointer batt→curr→brake→torque→batt.
  - If the scheduled slot is torque and pend_tq is also set, the single torque conversion satisfies both; clear both flags.
  - On any selection, go to START.
- FSM START: strt_cnv=1 for exactly one cycle, chnnl = selected channel; go to WAIT. chnnl is driven at the selection edge and held stable from START through LATCH.
- FSM WAIT:
  - Timeout counter starts at 0 on entry.
  - On cnv_cmplt, go to LATCH.
  - If the timeout counter reaches TIMEOUT-1 without cnv_cmplt: pulse err_to, no register write, go to IDLE.
  - A cnv_cmplt seen in IDLE or START is ignored.
- FSM LATCH: write res into the selected register; pulse the matching upd bit for one cycle; go to IDLE.
- Latency:
  - pend flag set in IDLE → strt_cnv 1 cycle later.
  - cnv_cmplt → register/upd visible 1 cycle later (registered in LATCH, observable next edge).
- Simultaneous events:
  - tick and pend_tq both pending: torque served first; pend_tick survives, so the scheduled channel is serviced immediately on the next IDLE.
  - cadence_rise during a torque conversion re-sets pend_tq, giving a fresh torque sample next.
- Reset mid-conversion: FSM returns to IDLE, results discarded, registers cleared.

Decomposition:
- Package sensor_pkg:
  - channel enum {CH_BATT=3'd0, CH_CURR=3'd1, CH_BRAKE=3'd3, CH_TORQUE=3'd4}
  - state enum {IDLE, START, WAIT, LATCH}
  - interval/timeout localparams
- Sub-module sched_timer: parameterised interval counter producing tick, FAST_SIM-selected terminal count. The FSM, arbitration and result registers stay in a2d_sched.

Test Plan:
- FAST_SIM=1, A2D model returns res=chnnl*100 three cycles after strt_cnv → chnnl sequence 0,1,3,4,0 on successive ticks 64 cycles apart; batt=0, curr=100, brake=300, torque=400; one upd bit per conversion.
- Single cadence_rise mid-interval while IDLE → strt_cnv on the next cycle with chnnl=4; torque updated; next tick still services the rr channel (no skip).
- cadence_rise on the same cycle as tick, rr=curr → torque conversion first, then curr immediately after without waiting for the next tick.
- Suppress cnv_cmplt → err_to pulse exactly 1024 cycles after entering WAIT; registers unchanged; next tick services the following channel.
- Assert rst_n low during WAIT, then release → all outputs 0, strt_cnv stays low until the first tick; a late cnv_cmplt is ignored.
